fb_write_arbiter: RTL and testbench

- Shares the single framebuffer_monochrome write port (we / w_data_valid / busy handshake) between NUM_REQ independent pixel-writer clients, such as the test pattern writer, a text renderer and a sprite blitter.
- Round-robin, one transaction at a time.
- Sits between the client blocks and framebuffer_monochrome in oled_top; ssd1309_driver read path is untouched.

---
 rtl/fb_arb_pkg.sv | 17 +
 rtl/fb_write_arbiter_rr_pick.sv | 33 +++
 rtl/fb_write_arbiter.sv | 179 +++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_arb_pkg.sv
// rtl/fb_arb_pkg.sv - shared types and constants for the framebuffer write arbiter
package fb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int GRANT_ID_W = 3;

    // The counter must be able to hold TIMEOUT_CYCLES itself, hence the +1.
    function automatic int timeout_cnt_w(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/fb_write_arbiter_rr_pick.sv
// rtl/fb_write_arbiter_rr_pick.sv - combinational round-robin winner select starting after i_rr_ptr
module rr_pick
    import fb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]    i_req,
    input  logic [GRANT_ID_W-1:0] i_rr_ptr,
    output logic [NUM_REQ-1:0]    o_onehot,
    output logic [GRANT_ID_W-1:0] o_idx,
    output logic                  o_any_req
);

    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    // Scan from the farthest candidate back to the nearest so the nearest asserted one wins.
    always_comb begin : p_pick
        int j;
        j        = 0;
        o_onehot = '0;
        o_idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = (int'(i_rr_ptr) + k) % NUM_REQ;
            if ((i_req & (ONE << j)) != '0) begin
                o_onehot = ONE << j;
                o_idx    = GRANT_ID_W'(j);
            end
        end
    end

    assign o_any_req = |i_req;

endmodule

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - round-robin sharing of the framebuffer write port between pixel writers
// Optional: FB_WRITE_ARBITER_TIMEOUT_EN aborts a write whose fb_w_data_valid never arrives.
module fb_write_arbiter
    import fb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int COORD_W        = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*COORD_W-1:0] req_xpos,
    input  logic [NUM_REQ*COORD_W-1:0] req_ypos,
    input  logic [NUM_REQ*DATA_W-1:0]  req_din,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       err,
    output logic [GRANT_ID_W-1:0]      grant_id,
    output logic                       active,
    input  logic                       fb_rst_complete,
    input  logic                       fb_busy,
    output logic                       fb_we,
    output logic [COORD_W-1:0]         fb_w_xpos,
    output logic [COORD_W-1:0]         fb_w_ypos,
    output logic [DATA_W-1:0]          fb_din,
    input  logic                       fb_w_data_valid
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("fb_write_arbiter: parameter out of range");
    end

    arb_state_t              r_state;
    arb_state_t              w_state_next;
    logic [GRANT_ID_W-1:0]   r_rr_ptr;
    logic [GRANT_ID_W-1:0]   r_grant_id;
    logic [GRANT_ID_W-1:0]   w_pick_idx;
    logic [NUM_REQ-1:0]      w_pick_onehot;
    logic                    w_any_req;
    logic [NUM_REQ-1:0]      r_ack;
    logic                    r_fb_we;
    logic                    r_active;
    logic [COORD_W-1:0]      r_xpos;
    logic [COORD_W-1:0]      r_ypos;
    logic [DATA_W-1:0]       r_din;
    logic [COORD_W-1:0]      w_sel_x;
    logic [COORD_W-1:0]      w_sel_y;
    logic [DATA_W-1:0]       w_sel_d;
    logic                    w_start;
    logic                    w_finish;
    logic                    w_timeout;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req     (req),
        .i_rr_ptr  (r_rr_ptr),
        .o_onehot  (w_pick_onehot),
        .o_idx     (w_pick_idx),
        .o_any_req (w_any_req)
    );

    always_comb begin
        w_sel_x = '0;
        w_sel_y = '0;
        w_sel_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_onehot[i]) begin
                w_sel_x = req_xpos[i*COORD_W +: COORD_W];
                w_sel_y = req_ypos[i*COORD_W +: COORD_W];
                w_sel_d = req_din[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // RELEASE holds until valid drops so a stretched valid cannot complete a second write.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (fb_rst_complete && !fb_busy && w_any_req) begin
                    w_start      = 1'b1;
                    w_state_next = GRANT;
                end
            end
            GRANT: begin
                if (fb_w_data_valid || w_timeout) begin
                    w_finish     = 1'b1;
                    w_state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!fb_w_data_valid) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= GRANT_ID_W'(NUM_REQ - 1);
            r_grant_id <= '0;
            r_ack      <= '0;
            r_fb_we    <= 1'b0;
            r_active   <= 1'b0;
            r_xpos     <= '0;
            r_ypos     <= '0;
            r_din      <= '0;
        end else begin
            r_ack <= '0;
            if (w_start) begin
                r_fb_we    <= 1'b1;
                r_active   <= 1'b1;
                r_grant_id <= w_pick_idx;
                r_xpos     <= w_sel_x;
                r_ypos     <= w_sel_y;
                r_din      <= w_sel_d;
            end
            if (w_finish) begin
                r_fb_we  <= 1'b0;
                r_active <= 1'b0;
                r_ack    <= NUM_REQ'(1) << r_grant_id;
                r_rr_ptr <= r_grant_id;
            end
        end
    end

`ifdef FB_WRITE_ARBITER_TIMEOUT_EN
    localparam int               CNT_W    = timeout_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_err;

    // Counter reads CNT_LAST on the TIMEOUT_CYCLES-th GRANT cycle, so fb_we is high exactly that long.
    assign w_timeout = (r_state == GRANT) && !fb_w_data_valid && (r_to_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (w_start) begin
                r_to_cnt <= '0;
            end else if (r_state == GRANT) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    assign ack       = r_ack;
    assign grant_id  = r_grant_id;
    assign active    = r_active;
    assign fb_we     = r_fb_we;
    assign fb_w_xpos = r_xpos;
    assign fb_w_ypos = r_ypos;
    assign fb_din    = r_din;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb/tb_fb_write_arbiter.sv - randomized and directed bench for fb_write_arbiter against a behavioural model
module tb_fb_write_arbiter;

    localparam int N  = 4;
    localparam int CW = 8;
    localparam int DW = 8;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N*CW-1:0]   req_xpos = '0;
    logic [N*CW-1:0]   req_ypos = '0;
    logic [N*DW-1:0]   req_din = '0;
    logic [N-1:0]      ack;
    logic              err;
    logic [2:0]        grant_id;
    logic              active;
    logic              fb_rst_complete = 1'b1;
    logic              fb_busy = 1'b0;
    logic              fb_we;
    logic [CW-1:0]     fb_w_xpos;
    logic [CW-1:0]     fb_w_ypos;
    logic [DW-1:0]     fb_din;
    logic              fb_w_data_valid = 1'b0;

    fb_write_arbiter #(
        .NUM_REQ        (N),
        .COORD_W        (CW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .req_xpos        (req_xpos),
        .req_ypos        (req_ypos),
        .req_din         (req_din),
        .ack             (ack),
        .err             (err),
        .grant_id        (grant_id),
        .active          (active),
        .fb_rst_complete (fb_rst_complete),
        .fb_busy         (fb_busy),
        .fb_we           (fb_we),
        .fb_w_xpos       (fb_w_xpos),
        .fb_w_ypos       (fb_w_ypos),
        .fb_din          (fb_din),
        .fb_w_data_valid (fb_w_data_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;
    int dut_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the port, what was latched, and what pulses this cycle.
    int          m_phase;   // 0 idle, 1 write outstanding, 2 waiting for valid to drop
    int          m_ptr;
    int          m_gid;
    int          m_to;
    logic        m_we, m_act, m_err;
    logic [N-1:0] m_ack;
    logic [CW-1:0] m_x, m_y;
    logic [DW-1:0] m_d;

    task automatic model_reset();
        m_phase = 0; m_ptr = N - 1; m_gid = 0; m_to = 0;
        m_we = 0; m_act = 0; m_err = 0; m_ack = '0;
        m_x = '0; m_y = '0; m_d = '0;
    endtask

    task automatic model_done(input logic timed_out);
        m_we = 0; m_act = 0;
        m_ack = N'(1) << m_gid;
        m_err = timed_out;
        m_ptr = m_gid;
        m_phase = 2;
    endtask

    task automatic model_step();
        int c;
        logic found;
        m_ack = '0;
        m_err = 0;
        found = 0;
        if (m_phase == 0) begin
            if (fb_rst_complete && !fb_busy && req != '0) begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_ptr + k) % N;
                    if (!found && req[c]) begin
                        found = 1;
                        m_gid = c;
                    end
                end
                m_x = req_xpos[m_gid*CW +: CW];
                m_y = req_ypos[m_gid*CW +: CW];
                m_d = req_din[m_gid*DW +: DW];
                m_we = 1; m_act = 1; m_to = 0; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (fb_w_data_valid) begin
                model_done(1'b0);
            end else begin
`ifdef FB_WRITE_ARBITER_TIMEOUT_EN
                m_to++;
                if (m_to == TO) model_done(1'b1);
`endif
            end
        end else begin
            if (!fb_w_data_valid) m_phase = 0;
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else model_step();
        #1;
        if (chk_en) begin
            chk("fb_we", 32'(fb_we), 32'(m_we));
            chk("active", 32'(active), 32'(m_act));
            chk("ack", 32'(ack), 32'(m_ack));
            chk("err", 32'(err), 32'(m_err));
            chk("grant_id", 32'(grant_id), 32'(m_gid));
            chk("fb_w_xpos", 32'(fb_w_xpos), 32'(m_x));
            chk("fb_w_ypos", 32'(fb_w_ypos), 32'(m_y));
            chk("fb_din", 32'(fb_din), 32'(m_d));
            chk("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
            for (int i = 0; i < N; i++) if (ack[i]) dut_log.push_back(i);
        end
    end

    // Framebuffer responder: valid follows fb_we after a delay; random mode also glitches valid while idle.
    bit resp_en = 1'b1;
    bit rand_mode = 1'b0;
    int resp_delay = 1;
    int rs_cnt = -1;
    int rs_hold = 0;

    always @(negedge clk) begin
        if (!resp_en) begin
            fb_w_data_valid = 1'b0; rs_cnt = -1; rs_hold = 0;
        end else if (fb_w_data_valid) begin
            if (rs_hold > 0) rs_hold--;
            else fb_w_data_valid = 1'b0;
        end else if (rs_cnt > 0) begin
            rs_cnt--;
        end else if (rs_cnt == 0) begin
            fb_w_data_valid = 1'b1;
            rs_hold = rand_mode ? int'($urandom_range(0, 1)) : 0;
            rs_cnt = -1;
        end else if (fb_we) begin
            rs_cnt = rand_mode ? int'($urandom_range(0, 4)) : resp_delay;
        end else if (rand_mode && $urandom_range(0, 19) == 0) begin
            fb_w_data_valid = 1'b1; rs_hold = 0;
        end
    end

    task automatic set_payload(input int i, input logic [7:0] x, input logic [7:0] y, input logic [7:0] d);
        req_xpos[i*CW +: CW] = x;
        req_ypos[i*CW +: CW] = y;
        req_din[i*DW +: DW]  = d;
    endtask

    // Waits (bounded) for an ack, then drops the acked requests on the following negedge.
    task automatic finish_txn(input int max_cyc, output logic [N-1:0] a, output logic e,
                              output int we_cyc, output int first_we);
        bit done;
        done = 0; a = '0; e = 0; we_cyc = 0; first_we = 0;
        for (int c = 1; c <= max_cyc && !done; c++) begin
            @(posedge clk); #1;
            if (ack != '0) begin
                a = ack; e = err; done = 1;
            end else if (fb_we) begin
                we_cyc++;
                if (first_we == 0) first_we = c;
            end
        end
        chk("ack_within_bound", 32'(a != '0), 32'd1);
        @(negedge clk);
        req = req & ~a;
    endtask

    logic [N-1:0] a;
    logic         e;
    int           wc, fw;
    bit           bad;

    initial begin
        model_reset();
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_fb_we", 32'(fb_we), 32'd0);
        chk("reset_grant_id", 32'(grant_id), 32'd0);
        chk("reset_outputs", {fb_w_xpos, fb_w_ypos, fb_din, 8'(ack)}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single client 2, valid returned after a fixed delay.
        @(negedge clk);
        set_payload(2, 8'd5, 8'd3, 8'hFF);
        req = 4'b0100;
        finish_txn(20, a, e, wc, fw);
        chk("t1_first_we", 32'(fw), 32'd1);
        chk("t1_we_cycles", 32'(wc), 32'd3);
        chk("t1_ack", 32'(a), 32'b0100);
        chk("t1_payload", {8'd0, fb_w_xpos, fb_w_ypos, fb_din}, 32'h0005_03FF);
        @(posedge clk); #1;
        chk("t1_ack_one_pulse", 32'(ack), 32'd0);
        chk("t1_active_low", 32'(active), 32'd0);

        // Clients 0 and 1 continuously: strict alternation.
        @(negedge clk);
        dut_log.delete();
        set_payload(0, 8'd10, 8'd11, 8'h12);
        set_payload(1, 8'd20, 8'd21, 8'h22);
        req = 4'b0011;
        for (int c = 0; c < 300 && dut_log.size() < 6; c++) @(negedge clk);
        req = '0;
        chk("t2_six_txns", 32'(dut_log.size() >= 6), 32'd1);
        for (int i = 0; i < 6; i++)
            if (i < dut_log.size()) chk("t2_grant_order", 32'(dut_log[i]), 32'(i % 2));
        repeat (4) @(negedge clk);

        // Framebuffer clear not finished: no write until fb_rst_complete.
        fb_rst_complete = 1'b0;
        set_payload(3, 8'd33, 8'd34, 8'h35);
        req = 4'b1000;
        bad = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (fb_we) bad = 1;
        end
        chk("t3_no_we_before_clear", 32'(bad), 32'd0);
        @(negedge clk);
        fb_rst_complete = 1'b1;
        finish_txn(20, a, e, wc, fw);
        chk("t3_grant_latency", 32'(fw >= 1 && fw <= 2), 32'd1);
        chk("t3_ack", 32'(a), 32'b1000);
        repeat (3) @(negedge clk);

        // Busy framebuffer holds off the grant.
        fb_busy = 1'b1;
        set_payload(1, 8'd40, 8'd41, 8'h42);
        req = 4'b0010;
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (fb_we || active) bad = 1;
        end
        chk("t4_no_grant_while_busy", 32'(bad), 32'd0);
        @(negedge clk);
        fb_busy = 1'b0;
        finish_txn(20, a, e, wc, fw);
        chk("t4_we_after_busy", 32'(fw), 32'd1);
        chk("t4_ack", 32'(a), 32'b0010);
        repeat (3) @(negedge clk);

        // Reset during a write: last completed was client 2, so only reset makes client 0 win over 3.
        set_payload(2, 8'd50, 8'd51, 8'h52);
        req = 4'b0100;
        finish_txn(20, a, e, wc, fw);
        chk("t5_pre_ack", 32'(a), 32'b0100);
        repeat (2) @(negedge clk);
        resp_en = 1'b0;
        req = 4'b0010;
        bad = 1;
        for (int c = 0; c < 10 && bad; c++) begin
            @(posedge clk); #1;
            if (fb_we) bad = 0;
        end
        chk("t5_we_before_reset", 32'(fb_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_we_drop", 32'(fb_we), 32'd0);
        chk("t5_no_ack_on_reset", 32'(ack), 32'd0);
        chk("t5_active_drop", 32'(active), 32'd0);
        repeat (2) @(negedge clk);
        set_payload(0, 8'd60, 8'd61, 8'h62);
        set_payload(3, 8'd70, 8'd71, 8'h72);
        req = 4'b1001;
        rst_n = 1'b1;
        resp_en = 1'b1;
        finish_txn(20, a, e, wc, fw);
        chk("t5_client0_first", 32'(a), 32'b0001);
        chk("t5_payload0", {8'd0, fb_w_xpos, fb_w_ypos, fb_din}, 32'h003C_3D62);
        finish_txn(20, a, e, wc, fw);
        chk("t5_client3_next", 32'(a), 32'b1000);
        req = '0;
        repeat (3) @(negedge clk);

`ifdef FB_WRITE_ARBITER_TIMEOUT_EN
        // Valid never comes: abort after TO cycles, then the next requester is served.
        resp_en = 1'b0;
        set_payload(1, 8'd80, 8'd81, 8'h82);
        set_payload(2, 8'd90, 8'd91, 8'h92);
        req = 4'b0110;
        finish_txn(40, a, e, wc, fw);
        chk("t6_we_cycles", 32'(wc), 32'(TO));
        chk("t6_ack", 32'(a), 32'b0010);
        chk("t6_err_with_ack", 32'(e), 32'd1);
        resp_en = 1'b1;
        finish_txn(40, a, e, wc, fw);
        chk("t6_next_ack", 32'(a), 32'b0100);
        chk("t6_next_no_err", 32'(e), 32'd0);
        req = '0;
        repeat (3) @(negedge clk);
`endif

        // Randomized clients, busy, clear status and responder latency.
        rand_mode = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    set_payload(i, 8'($urandom), 8'($urandom), 8'($urandom));
                    req[i] = 1'b1;
                end else if (req[i] && $urandom_range(0, 63) == 0) begin
                    req[i] = 1'b0;
                end
            end
            fb_busy = ($urandom_range(0, 4) == 0);
            fb_rst_complete = ($urandom_range(0, 19) != 0);
        end
        req = '0;
        fb_busy = 1'b0;
        fb_rst_complete = 1'b1;
        rand_mode = 1'b0;
        repeat (40) @(negedge clk);
        chk("final_idle", 32'(active), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
